// File: rtl/fft_sequencer_pkg.sv
// Shared types and width helpers for the FFT sequencer and its AGU.
// Widths are functions of N so every FFT-side block derives them identically.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEFAULT = 32;

  function automatic int stage_w(input int n);
    return $clog2($clog2(n));
  endfunction

  function automatic int pair_w(input int n);
    return $clog2(n / 2);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n / 2) + 1;
  endfunction

  localparam int STAGE_W = stage_w(N_DEFAULT);
  localparam int PAIR_W  = pair_w(N_DEFAULT);
  localparam int CNT_W   = cnt_w(N_DEFAULT);

endpackage

// File: rtl/fft_sequencer_if.sv
// Sequencer bundle: controller and write-back inputs, AGU-facing outputs.
// The master side is the sequencer; the slave side is controller plus datapath.
interface fft_sequencer_if #(
  parameter int N = 32
);
  import fft_pkg::*;

  localparam int SW = stage_w(N);
  localparam int PW = pair_w(N);

  logic          start;
  logic          stall;
  logic          wb_valid;
  logic [SW-1:0] stage;
  logic [PW-1:0] pair_id;
  logic          o_valid;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start,
    input  stall,
    input  wb_valid,
    output stage,
    output pair_id,
    output o_valid,
    output busy,
    output done,
    output err
  );

  modport slave (
    output start,
    output stall,
    output wb_valid,
    input  stage,
    input  pair_id,
    input  o_valid,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/fft_sequencer_inflight_counter.sv
// Counts butterflies issued but not yet written back.
// A retirement with nothing in flight saturates at zero and flags underflow.
module inflight_counter
  import fft_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          underflow
);

  logic [CW-1:0] count_n;

  assign underflow = dec & ~inc & (count == '0);

  always_comb begin
    count_n = count;
    unique case ({inc, dec})
      2'b10: count_n = count + 1'b1;
      2'b01: count_n = (count == '0) ? count : count - 1'b1;
      default: count_n = count;
    endcase
    if (clear) count_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_n;
  end

endmodule

// File: rtl/fft_sequencer.sv
// Sweeps every (stage, pair) of a radix-2 in-place FFT and holds each
// stage boundary until all write-backs of the previous stage have retired.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             reset,
  fft_sequencer_if.master  bus
);

  localparam int SW = stage_w(N);
  localparam int PW = pair_w(N);
  localparam int CW = cnt_w(N);

  localparam logic [SW-1:0] LAST_STAGE = SW'($clog2(N) - 1);
  localparam logic [PW-1:0] LAST_PAIR  = PW'(N / 2 - 1);

  state_t        state, state_n;
  logic [SW-1:0] stage_q, stage_n;
  logic [PW-1:0] pair_q, pair_n;
  logic          err_q, err_n;
  logic          issue;
  logic          accept;
  logic [CW-1:0] count;
  logic          underflow;

  assign issue  = (state == ISSUE) & ~bus.stall;
  assign accept = (state == IDLE) & bus.start;

  inflight_counter #(.CW(CW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .inc       (issue),
    .dec       (bus.wb_valid),
    .count     (count),
    .underflow (underflow)
  );

  always_comb begin
    state_n = state;
    stage_n = stage_q;
    pair_n  = pair_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ISSUE;
          stage_n = '0;
          pair_n  = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (pair_q == LAST_PAIR) begin
            pair_n  = '0;
            state_n = DRAIN;
          end else begin
            pair_n = pair_q + 1'b1;
          end
        end
      end
      // Registered count: at least one drain cycle per stage.
      DRAIN: begin
        if (count == '0) begin
          if (stage_q == LAST_STAGE) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            stage_n = stage_q + 1'b1;
            pair_n  = '0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        stage_n = '0;
        pair_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    err_n = err_q;
    if (accept)    err_n = 1'b0;
    if (underflow) err_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      stage_q <= stage_n;
      pair_q  <= pair_n;
      err_q   <= err_n;
    end
  end

  assign bus.stage   = stage_q;
  assign bus.pair_id = pair_q;
  assign bus.o_valid = issue;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer (N=8): directed timing cases plus
// randomized stall / write-back latency against a transform-level model.
module tb_fft_sequencer;

  localparam int N   = 8;
  localparam int H   = N / 2;
  localparam int L   = $clog2(N);
  localparam int TOT = L * H;

  logic clk = 1'b0;
  logic reset;

  fft_sequencer_if #(.N(N)) bus ();

  fft_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stage;
    int pair;
    int cyc;
  } iss_t;

  typedef struct {
    bit busy;
    bit done;
    bit err;
    bit idle;
  } st_t;

  iss_t iss_q[$];
  int   done_q[$];
  st_t  st_q[$];
  int   wbq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -1;

  // Transform-level model: phase 0 idle, 1 issuing, 2 waiting, 3 finished.
  // k counts butterflies issued so far in the current transform.
  int ph = 0;
  int k = 0;
  int cnt = 0;
  bit m_err = 1'b0;

  bit drv_start, drv_stall, drv_stray, drv_reset;
  int cur_lat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit iss, wb;
    int idx, lat, cnt0;
    @(posedge clk);
    #1;
    cyc++;
    reset = drv_reset;
    if (drv_reset) begin
      ph = 0; k = 0; cnt = 0; m_err = 1'b0;
      wbq.delete(); iss_q.delete(); done_q.delete();
      bus.start = 1'b0; bus.stall = 1'b0; bus.wb_valid = 1'b0;
      st_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
      return;
    end
    iss = (ph == 1) && !drv_stall;
    if (iss) begin
      lat = (cur_lat < 0) ? int'($urandom_range(0, 4)) : cur_lat;
      wbq.push_back(cyc + lat);
      iss_q.push_back('{k / H, k % H, cyc});
    end
    wb = 1'b0;
    idx = -1;
    foreach (wbq[i])
      if (wbq[i] <= cyc && (idx < 0 || wbq[i] < wbq[idx])) idx = i;
    if (idx >= 0) begin
      wb = 1'b1;
      wbq.delete(idx);
    end else begin
      wb = drv_stray;
    end
    bus.start = drv_start;
    bus.stall = drv_stall;
    bus.wb_valid = wb;
    st_q.push_back('{ph != 0, ph == 3, m_err, ph == 0});
    if (ph == 3) done_q.push_back(cyc);
    cnt0 = cnt;
    if (iss && !wb) cnt++;
    else if (!iss && wb) begin
      if (cnt == 0) m_err = 1'b1;
      else cnt--;
    end
    case (ph)
      0: if (drv_start) begin ph = 1; k = 0; cnt = 0; m_err = 1'b0; end
      1: if (iss) begin k++; if (k % H == 0) ph = 2; end
      2: if (cnt0 == 0) ph = (k == TOT) ? 3 : 1;
      default: ph = 0;
    endcase
  endtask

  always @(negedge clk) begin
    st_t  e;
    iss_t x;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      check("busy", int'(bus.busy), int'(e.busy));
      check("done", int'(bus.done), int'(e.done));
      check("err", int'(bus.err), int'(e.err));
      if (e.idle) begin
        check("idle_stage", int'(bus.stage), 0);
        check("idle_pair", int'(bus.pair_id), 0);
        check("idle_valid", int'(bus.o_valid), 0);
      end
      if (bus.o_valid === 1'b1) begin
        if (iss_q.size() == 0) check("unexpected_issue", int'(bus.o_valid), 0);
        else begin
          x = iss_q.pop_front();
          check("issue_stage", int'(bus.stage), x.stage);
          check("issue_pair", int'(bus.pair_id), x.pair);
          check("issue_cycle", cyc, x.cyc);
        end
      end else if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        check("missing_issue", int'(bus.o_valid), 1);
        void'(iss_q.pop_front());
      end
      if (bus.done === 1'b1) begin
        last_done = cyc;
        if (done_q.size() == 0) check("unexpected_done", int'(bus.done), 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic run(input int lat, input int st_lo, input int st_hi,
                     input int restart_at, input int reset_at,
                     input bit rnd, output int dur);
    int c0, rel;
    bit fin;
    cur_lat = lat;
    c0 = cyc + 1;
    last_done = -1;
    rel = 0;
    fin = 1'b0;
    while (!fin) begin
      drv_start = (rel == 0) || (rel == restart_at);
      drv_stall = rnd ? ($urandom_range(0, 9) < 3) : (rel >= st_lo && rel <= st_hi);
      drv_reset = (rel == reset_at);
      drv_stray = rnd && rel > 0 && ($urandom_range(0, 49) == 0);
      tick();
      rel++;
      if (rel > 1 && ph == 0 && wbq.size() == 0) fin = 1'b1;
      if (rel > 400) begin
        check("timeout_phase", ph, 0);
        fin = 1'b1;
      end
    end
    drv_start = 1'b0; drv_stall = 1'b0; drv_reset = 1'b0; drv_stray = 1'b0;
    tick();
    dur = (last_done < 0) ? -1 : last_done - c0;
  endtask

  initial begin
    int d;
    reset = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.wb_valid = 1'b0;
    drv_start = 1'b0; drv_stall = 1'b0; drv_stray = 1'b0; drv_reset = 1'b0;
    cur_lat = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_stage", int'(bus.stage), 0);
    check("rst_pair", int'(bus.pair_id), 0);
    repeat (2) tick();

    run(3, 1, 0, -1, -1, 1'b0, d);
    check("nominal_done_rel", d, 25);

    run(3, 2, 3, -1, -1, 1'b0, d);
    check("stall_done_rel", d, 27);

    run(0, 1, 0, -1, -1, 1'b0, d);
    check("zero_lat_done_rel", d, 16);

    drv_stray = 1'b1;
    tick();
    drv_stray = 1'b0;
    repeat (2) tick();
    check("underflow_err_sticky", int'(bus.err), 1);
    run(3, 1, 0, -1, -1, 1'b0, d);
    check("after_underflow_done_rel", d, 25);
    check("err_cleared", int'(bus.err), 0);

    run(3, 1, 0, -1, 14, 1'b0, d);
    check("abort_no_done", d, -1);
    run(3, 1, 0, -1, -1, 1'b0, d);
    check("rerun_done_rel", d, 25);

    run(3, 1, 0, 5, -1, 1'b0, d);
    check("restart_ignored_done_rel", d, 25);

    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      run(-1, 0, 0, int'($urandom_range(1, 30)), -1, 1'b1, d);
      check("rand_done_seen", int'(d > 0), 1);
    end

    check("left_issues", iss_q.size(), 0);
    check("left_dones", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
